axis_block_packer: RTL and testbench
====================================

AXIS_BLOCK_PACKER -- requirements
Module: axis_block_packer

Interface
REQ-001 Parameter TDATA_WIDTH, default 32, SHALL set the input stream data width in bits; only 32 is supported.
REQ-002 Parameter BLOCK_WIDTH, default 128, SHALL set the output block width in bits; only 128 is supported (BEATS = BLOCK_WIDTH/TDATA_WIDTH = 4).
REQ-003 aclk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 aresetn  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 s_tvalid  in  1  input beat valid.
REQ-006 s_tready  out  1  input beat accepted when high together with s_tvalid.
REQ-007 s_tdata  in  32  input beat data.
REQ-008 s_tkeep  in  4  input byte-lane enables.
REQ-009 s_tlast  in  1  last beat of packet.
REQ-010 s_tuser  in  1  packet sideband (e.g. key/data select).
REQ-011 m_tvalid  out  1  output block valid.
REQ-012 m_tready  in  1  downstream ready.
REQ-013 m_tdata  out  128  assembled block.
REQ-014 m_tkeep  out  16  block byte enables.
REQ-015 m_tlast  out  1  block ends the packet.
REQ-016 m_tuser  out  1  sideband of the block.

Function
REQ-017 Block SHALL be assembled little-endian by beat: beat k (k = 0..3) lands in m_tdata[32k+31:32k] and m_tkeep[4k+3:4k].
REQ-018 An input transfer SHALL occur when s_tvalid && s_tready; an output transfer SHALL occur when m_tvalid && m_tready.
REQ-019 States SHALL be FILL (collecting, m_tvalid=0) and HOLD (block presented, m_tvalid=1); reset state SHALL be FILL.
REQ-020 s_tready SHALL equal (state==FILL) || m_tready, so the next block's beat 0 can be accepted in the same cycle a block is consumed.
REQ-021 Beat counter SHALL be 2 bits; it increments per accepted beat and wraps 3->0.
REQ-022 FILL->HOLD SHALL happen on the edge that accepts beat 3 or any beat with s_tlast=1; m_tvalid rises the next cycle (1-cycle latency from the final beat).
REQ-023 On an s_tlast beat with count < 3, unfilled lanes SHALL be driven with m_tdata = 0 and m_tkeep = 0; m_tlast SHALL be 1.
REQ-024 On a full block without s_tlast, m_tlast SHALL be 0.
REQ-025 m_tuser SHALL be the s_tuser captured on beat 0 of the block; later beats' s_tuser SHALL be ignored.
REQ-026 HOLD->FILL SHALL happen on an output transfer with no simultaneous input transfer; with a simultaneous input transfer, that beat SHALL become beat 0 of the next block (or, if it carries s_tlast, the block SHALL return straight to HOLD).
REQ-027 In HOLD with m_tready=0, m_tdata, m_tkeep, m_tlast and m_tuser SHALL stay stable and s_tready SHALL be 0.
REQ-028 A beat with s_tkeep=0 SHALL still count as a beat; if it is beat 0 with s_tlast, the block SHALL have m_tkeep = 0 and m_tlast = 1.
REQ-029 The assembly register SHALL be cleared to 0 when each new block starts, so no stale bytes leak into padded lanes.

Reset
REQ-030 While aresetn=0: state=FILL, count=0, m_tvalid=0, m_tdata=0, m_tkeep=0, m_tlast=0, m_tuser=0; s_tready SHALL read 1 once aresetn=1.
REQ-031 Reset asserted mid-block or in HOLD SHALL discard the partial or held block immediately; the next accepted beat is beat 0.

Configuration
REQ-032 Macro AXIS_BLOCK_PACKER_ERR_EN, when defined, SHALL add output port err (1 bit, reset 0). err is set sticky on any accepted beat with s_tlast=0 and s_tkeep != 4'hF, or with non-contiguous s_tkeep (not 0/1/3/7/F), and is cleared only by reset; data handling is unchanged.
REQ-033 Without AXIS_BLOCK_PACKER_ERR_EN, port err and its logic SHALL be absent and keep patterns SHALL be passed through unchecked.

Verification
REQ-034 4 beats 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, keep F, last on beat 3, m_tready=1 -> one block m_tdata=0x0F0E..0100, m_tkeep=FFFF, m_tlast=1, m_tvalid 1 cycle after beat 3.
REQ-035 2 beats A0A0A0A0, B1B1B1B1 (keep F, then keep 3, last) -> m_tdata=0x...0000B1B1A0A0A0A0, m_tkeep=0x003F, m_tlast=1.
REQ-036 8 back-to-back beats, no last, m_tready=1 -> 2 blocks, m_tlast=0, s_tready held at 1 throughout (no bubble).
REQ-037 m_tready=0 for 5 cycles in HOLD -> s_tready=0, outputs stable; on m_tready=1 the block is consumed and a pending beat is accepted the same cycle.
REQ-038 aresetn pulsed low after 2 beats -> all outputs 0; the next 4 beats form a clean block with no stale data.
REQ-039 With AXIS_BLOCK_PACKER_ERR_EN, a non-last beat with keep=7 -> err=1 and stays 1 until reset; without the macro, the same stimulus produces the identical block.

Source files
------------

// File: rtl/axis_block_packer.sv
//------------------------------------------------------------------------------
// axis_block_packer: packs 32-bit AXI-Stream beats into 128-bit blocks.
// Optional sticky keep-pattern error output enabled by AXIS_BLOCK_PACKER_ERR_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module axis_block_packer #(
    parameter int TDATA_WIDTH = 32,
    parameter int BLOCK_WIDTH = 128
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    input  logic [TDATA_WIDTH-1:0]   s_tdata,
    input  logic [TDATA_WIDTH/8-1:0] s_tkeep,
    input  logic                     s_tlast,
    input  logic                     s_tuser,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [BLOCK_WIDTH-1:0]   m_tdata,
    output logic [BLOCK_WIDTH/8-1:0] m_tkeep,
    output logic                     m_tlast,
    output logic                     m_tuser
`ifdef AXIS_BLOCK_PACKER_ERR_EN
    ,
    output logic                     err
`endif
);

    localparam int         KW        = TDATA_WIDTH / 8;
    localparam int         BEATS     = BLOCK_WIDTH / TDATA_WIDTH;
    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [1:0]               r_cnt;
    logic [BLOCK_WIDTH-1:0]   r_data;
    logic [BLOCK_WIDTH/8-1:0] r_keep;
    logic                     r_last;
    logic                     r_user;
    logic [TDATA_WIDTH-1:0]   w_beat_data;
    logic                     w_in_xfer;
    logic                     w_out_xfer;
    logic                     w_blk_done;

    assign s_tready   = (r_state == FILL) || m_tready;
    assign m_tvalid   = (r_state == HOLD);
    assign m_tdata    = r_data;
    assign m_tkeep    = r_keep;
    assign m_tlast    = r_last;
    assign m_tuser    = r_user;

    assign w_in_xfer  = s_tvalid && s_tready;
    assign w_out_xfer = m_tvalid && m_tready;
    assign w_blk_done = w_in_xfer && ((r_cnt == LAST_BEAT) || s_tlast);

    // Null bytes (keep=0) are stored as zero so they never carry stray data.
    always_comb begin
        w_beat_data = '0;
        for (int b = 0; b < KW; b++) begin
            w_beat_data[8*b +: 8] = s_tkeep[b] ? s_tdata[8*b +: 8] : 8'h00;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FILL: begin
                if (w_blk_done) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (w_blk_done) begin
                    w_state_nxt = HOLD;
                end else if (w_out_xfer) begin
                    w_state_nxt = FILL;
                end
            end
            default: w_state_nxt = FILL;
        endcase
    end

    // Beat 0 rebuilds the whole assembly register so padded lanes read as zero.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_cnt  <= '0;
            r_data <= '0;
            r_keep <= '0;
            r_last <= 1'b0;
            r_user <= 1'b0;
        end else if (w_in_xfer) begin
            if (r_cnt == 2'd0) begin
                r_data <= {{(BLOCK_WIDTH - TDATA_WIDTH){1'b0}}, w_beat_data};
                r_keep <= {{(BLOCK_WIDTH/8 - KW){1'b0}}, s_tkeep};
                r_user <= s_tuser;
            end else begin
                r_data[TDATA_WIDTH*r_cnt +: TDATA_WIDTH] <= w_beat_data;
                r_keep[KW*r_cnt +: KW]                   <= s_tkeep;
            end
            r_last <= s_tlast;
            r_cnt  <= w_blk_done ? 2'd0 : r_cnt + 2'd1;
        end
    end

`ifdef AXIS_BLOCK_PACKER_ERR_EN
    logic w_keep_contig;
    logic w_keep_bad;

    assign w_keep_contig = (s_tkeep == 4'h0) || (s_tkeep == 4'h1) || (s_tkeep == 4'h3) ||
                           (s_tkeep == 4'h7) || (s_tkeep == 4'hF);
    assign w_keep_bad    = (!s_tlast && (s_tkeep != 4'hF)) || !w_keep_contig;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err <= 1'b0;
        end else if (w_in_xfer && w_keep_bad) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_axis_block_packer.sv
//------------------------------------------------------------------------------
// tb_axis_block_packer: directed and randomized checks of axis_block_packer
// against a block-level reference model. Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_axis_block_packer;

    logic         aclk     = 1'b0;
    logic         aresetn  = 1'b0;
    logic         s_tvalid = 1'b0;
    logic         s_tready;
    logic [31:0]  s_tdata  = '0;
    logic [3:0]   s_tkeep  = '0;
    logic         s_tlast  = 1'b0;
    logic         s_tuser  = 1'b0;
    logic         m_tvalid;
    logic         m_tready = 1'b0;
    logic [127:0] m_tdata;
    logic [15:0]  m_tkeep;
    logic         m_tlast;
    logic         m_tuser;
`ifdef AXIS_BLOCK_PACKER_ERR_EN
    logic         err;
    logic         exp_err = 1'b0;
`endif

    axis_block_packer #(.TDATA_WIDTH(32), .BLOCK_WIDTH(128)) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tdata  (s_tdata),
        .s_tkeep  (s_tkeep),
        .s_tlast  (s_tlast),
        .s_tuser  (s_tuser),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tlast  (m_tlast),
        .m_tuser  (m_tuser)
`ifdef AXIS_BLOCK_PACKER_ERR_EN
        ,
        .err      (err)
`endif
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [127:0] d;
        logic [15:0]  k;
        logic         l;
        logic         u;
    } blk_t;

    blk_t   exp_q[$];
    blk_t   cur;
    blk_t   mon_e;
    int     mcnt    = 0;
    int     n_cmp   = 0;
    int     n_fail  = 0;
    int     blocks_seen = 0;
    bit     rnd_rdy = 1'b0;
    bit     held_v  = 1'b0;
    blk_t   held;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_cmp++;
        n_fail++;
        $error("FAIL %s: observed timeout expected progress", tag);
    endtask

    // Reference: each accepted beat fills the next 32-bit lane; a block closes
    // after 4 beats or on tlast; only kept bytes are nonzero; tuser from beat 0.
    task automatic model_beat(input logic [31:0] d, input logic [3:0] k, input logic l, input logic u);
        if (mcnt == 0) begin
            cur   = '0;
            cur.u = u;
        end
        for (int b = 0; b < 4; b++) begin
            if (k[b]) cur.d[32*mcnt + 8*b +: 8] = d[8*b +: 8];
            cur.k[4*mcnt + b] = k[b];
        end
`ifdef AXIS_BLOCK_PACKER_ERR_EN
        if ((!l && k != 4'hF) || !(k inside {4'h0, 4'h1, 4'h3, 4'h7, 4'hF})) exp_err = 1'b1;
`endif
        mcnt++;
        if (l || mcnt == 4) begin
            cur.l = l;
            exp_q.push_back(cur);
            mcnt = 0;
        end
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                             input logic u, output int waits);
        bit acc;
        acc      = 1'b0;
        waits    = 0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tuser  = u;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge aclk);
            acc = s_tready;
            if (!acc) waits++;
            @(posedge aclk);
            #1;
        end
        s_tvalid = 1'b0;
        if (acc) model_beat(d, k, l, u);
        else     timeout("send_beat");
    endtask

    initial begin
        forever begin
            @(posedge aclk);
            #1;
            if (rnd_rdy) m_tready = ($urandom_range(0, 3) != 0);
        end
    end

    // Output monitor: handshake rule, in-order block comparison, HOLD stability.
    always @(negedge aclk) begin
        if (aresetn) begin
            check("s_tready_rule", s_tready, (!m_tvalid) || m_tready);
            if (held_v) begin
                check("hold_valid", m_tvalid, 1'b1);
                check("hold_data", m_tdata, held.d);
                check("hold_keep", m_tkeep, held.k);
                check("hold_lastuser", {m_tlast, m_tuser}, {held.l, held.u});
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $error("FAIL unexpected_block: observed %h expected none", m_tdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("blk_data", m_tdata, mon_e.d);
                    check("blk_keep", m_tkeep, mon_e.k);
                    check("blk_last", m_tlast, mon_e.l);
                    check("blk_user", m_tuser, mon_e.u);
                    blocks_seen++;
                end
            end
            held_v = m_tvalid && !m_tready;
            held   = {m_tdata, m_tkeep, m_tlast, m_tuser};
        end else begin
            held_v = 1'b0;
        end
    end

    initial begin
        int w;
        int wsum;
        logic [31:0] rd;
        logic [3:0]  rk;

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        check("rst_valid", m_tvalid, 1'b0);
        check("rst_data", m_tdata, 128'h0);
        check("rst_keep", m_tkeep, 16'h0);
        check("rst_lastuser", {m_tlast, m_tuser}, 2'b00);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        check("rst_ready", s_tready, 1'b1);

        // Full 4-beat block ending in tlast, one-cycle latency
        m_tready = 1'b1;
        send_beat(32'h03020100, 4'hF, 1'b0, 1'b1, w);
        check("lat_pre_valid", m_tvalid, 1'b0);
        send_beat(32'h07060504, 4'hF, 1'b0, 1'b0, w);
        send_beat(32'h0B0A0908, 4'hF, 1'b0, 1'b0, w);
        send_beat(32'h0F0E0D0C, 4'hF, 1'b1, 1'b0, w);
        check("full_valid", m_tvalid, 1'b1);
        check("full_data", m_tdata, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
        check("full_keep", m_tkeep, 16'hFFFF);
        check("full_last", m_tlast, 1'b1);
        check("full_user", m_tuser, 1'b1);

        // Short block with partial keep on the last beat
        send_beat(32'hA0A0A0A0, 4'hF, 1'b0, 1'b0, w);
        send_beat(32'hB1B1B1B1, 4'h3, 1'b1, 1'b1, w);
        check("short_data", m_tdata, 128'h0000B1B1_A0A0A0A0);
        check("short_keep", m_tkeep, 16'h003F);
        check("short_last", m_tlast, 1'b1);
        check("short_user", m_tuser, 1'b0);

        // Eight back-to-back beats without tlast
        wsum = 0;
        for (int i = 0; i < 8; i++) begin
            send_beat($urandom, 4'hF, 1'b0, i[0], w);
            wsum += w;
        end
        check("b2b_no_bubble", wsum, 0);
        check("b2b_last", m_tlast, 1'b0);
        repeat (2) @(posedge aclk);
        #1;

        // Backpressure in HOLD with a pending beat
        m_tready = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(32'h11111111 * (i + 1), 4'hF, 1'b0, 1'b1, w);
        s_tvalid = 1'b1;
        s_tdata  = 32'hCAFEF00D;
        s_tkeep  = 4'hF;
        s_tlast  = 1'b1;
        s_tuser  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            check("bp_ready", s_tready, 1'b0);
            check("bp_data", m_tdata, 128'h44444444_33333333_22222222_11111111);
        end
        @(posedge aclk);
        #1;
        m_tready = 1'b1;
        @(negedge aclk);
        check("bp_release_ready", s_tready, 1'b1);
        @(posedge aclk);
        #1;
        s_tvalid = 1'b0;
        model_beat(32'hCAFEF00D, 4'hF, 1'b1, 1'b0);
        check("bp_next_valid", m_tvalid, 1'b1);
        check("bp_next_data", m_tdata, 128'hCAFEF00D);
        check("bp_next_keep", m_tkeep, 16'h000F);

        // Empty-keep single-beat block
        send_beat(32'hDEADBEEF, 4'h0, 1'b1, 1'b1, w);
        check("k0_keep", m_tkeep, 16'h0);
        check("k0_last", m_tlast, 1'b1);
        check("k0_data", m_tdata, 128'h0);

        // Reset mid-block discards the partial block
        send_beat(32'h55555555, 4'hF, 1'b0, 1'b1, w);
        send_beat(32'h66666666, 4'hF, 1'b0, 1'b1, w);
        aresetn = 1'b0;
        #2;
        check("mid_rst_valid", m_tvalid, 1'b0);
        check("mid_rst_data", m_tdata, 128'h0);
        check("mid_rst_keep", m_tkeep, 16'h0);
        check("mid_rst_lastuser", {m_tlast, m_tuser}, 2'b00);
`ifdef AXIS_BLOCK_PACKER_ERR_EN
        check("mid_rst_err", err, 1'b0);
        exp_err = 1'b0;
`endif
        mcnt = 0;
        exp_q.delete();
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        check("post_rst_ready", s_tready, 1'b1);
        send_beat(32'h13121110, 4'hF, 1'b0, 1'b0, w);
        send_beat(32'h17161514, 4'hF, 1'b0, 1'b0, w);
        send_beat(32'h1B1A1918, 4'hF, 1'b0, 1'b0, w);
        send_beat(32'h1F1E1D1C, 4'hF, 1'b0, 1'b0, w);
        check("post_rst_data", m_tdata, 128'h1F1E1D1C_1B1A1918_17161514_13121110);
        check("post_rst_user", m_tuser, 1'b0);
        send_beat(32'h77777777, 4'h1, 1'b1, 1'b1, w);
        check("post_rst_pad", m_tdata, 128'h00000077);

        // Non-last beat with keep=7
        send_beat(32'h00ABCDEF, 4'h7, 1'b0, 1'b0, w);
        send_beat(32'h12345678, 4'hF, 1'b1, 1'b0, w);
        check("k7_data", m_tdata, 128'h12345678_00ABCDEF);
        check("k7_keep", m_tkeep, 16'h00F7);
`ifdef AXIS_BLOCK_PACKER_ERR_EN
        check("k7_err", err, 1'b1);
`endif

        // Randomized traffic with random backpressure
        rnd_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            rd = $urandom;
            rk = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) begin
                @(posedge aclk);
                #1;
            end
            send_beat(rd, rk, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), w);
        end
        send_beat(32'h9ABCDEF0, 4'hF, 1'b1, 1'b1, w);
        rnd_rdy  = 1'b0;
        m_tready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge aclk);
        #1;
        if (exp_q.size() != 0) timeout("drain");
        check("drain_idle", m_tvalid, 1'b0);
`ifdef AXIS_BLOCK_PACKER_ERR_EN
        check("rand_err", err, exp_err);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed time limit expected finish");
        $fatal(1, "global timeout");
    end

endmodule

`default_nettype wire
